// File: rtl/adc_spi_capture_if.sv
// ADC capture bus: SPI pins toward the converter plus the sample output toward the audio path.
interface adc_spi_capture_if;
  logic       channel;
  logic       adc_dout;
  logic       adc_cs_n;
  logic       adc_sck;
  logic       adc_din;
  logic [9:0] data_out;
  logic       data_valid;
  logic       overrun;

  modport master (
    input  channel, adc_dout,
    output adc_cs_n, adc_sck, adc_din, data_out, data_valid, overrun
  );

  modport slave (
    output channel, adc_dout,
    input  adc_cs_n, adc_sck, adc_din, data_out, data_valid, overrun
  );
endinterface

// File: rtl/adc_spi_capture.sv
// adc_spi_capture: drives an MCP3002-style 10-bit SPI ADC at a fixed sample rate and presents
// each conversion on data_out with a data_valid level. Optional macro ADC_AVG2_EN averages each
// new sample with the previous raw sample (round half up).
module adc_spi_capture #(
  parameter int SCK_HALF      = 25,
  parameter int SAMPLE_PERIOD = 5000
) (
  input  logic                     sysclk,
  input  logic                     rst,
  adc_spi_capture_if.master        bus
);
  localparam int RW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   rate_q, rate_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      cs_hi_q, cs_hi_d;
  logic [3:0]      bit_q, bit_d;
  logic            sck_q, sck_d;
  logic            cs_n_q, cs_n_d;
  logic            din_q, din_d;
  logic [9:0]      shreg_q, shreg_d;
  logic [9:0]      data_out_q, data_out_d;
  logic            valid_q, valid_d;
  logic            vpend_q, vpend_d;
  logic            pending_q, pending_d;
  logic            overrun_q, overrun_d;
  logic            ch_q, ch_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            tick;
  logic            phase_end;
`ifdef ADC_AVG2_EN
  logic [9:0]      prev_q, prev_d;
  logic [10:0]     avg_sum;
`endif

  function automatic logic cmd_bit(input logic [3:0] idx, input logic ch);
    case (idx)
      4'd0, 4'd1, 4'd3: cmd_bit = 1'b1;
      4'd2:             cmd_bit = ch;
      default:          cmd_bit = 1'b0;
    endcase
  endfunction

  assign tick      = (rate_q == RW'(SAMPLE_PERIOD - 1));
  assign phase_end = (cnt_q == 8'(SCK_HALF - 1));

  // State register and all datapath flops
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rate_q     <= '0;
      cnt_q      <= '0;
      cs_hi_q    <= '0;
      bit_q      <= '0;
      sck_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      din_q      <= 1'b0;
      shreg_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      vpend_q    <= 1'b0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      ch_q       <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
`ifdef ADC_AVG2_EN
      prev_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rate_q     <= rate_d;
      cnt_q      <= cnt_d;
      cs_hi_q    <= cs_hi_d;
      bit_q      <= bit_d;
      sck_q      <= sck_d;
      cs_n_q     <= cs_n_d;
      din_q      <= din_d;
      shreg_q    <= shreg_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      vpend_q    <= vpend_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      ch_q       <= ch_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
`ifdef ADC_AVG2_EN
      prev_q     <= prev_d;
`endif
    end
  end

  // Rate counter, frame sequencing, SPI shifting and sample output
  always_comb begin
    state_d    = state_q;
    rate_d     = tick ? '0 : rate_q + 1'b1;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sck_d      = sck_q;
    cs_n_d     = cs_n_q;
    din_d      = din_q;
    shreg_d    = shreg_q;
    data_out_d = data_out_q;
    valid_d    = valid_q | vpend_q;
    vpend_d    = 1'b0;
    pending_d  = pending_q;
    overrun_d  = overrun_q | (tick & (pending_q | (state_q != ST_IDLE)));
    ch_d       = ch_q;
    sync1_d    = bus.adc_dout;
    sync2_d    = sync1_q;
`ifdef ADC_AVG2_EN
    prev_d     = prev_q;
    avg_sum    = {1'b0, shreg_q} + {1'b0, prev_q} + 11'd1;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pending_q && (cs_hi_q >= 8'(SCK_HALF))) begin
          state_d   = ST_SETUP;
          pending_d = 1'b0;
          ch_d      = bus.channel;
          bit_d     = '0;
          cnt_d     = '0;
          cs_n_d    = 1'b0;
          sck_d     = 1'b0;
          valid_d   = 1'b0;
          din_d     = cmd_bit(4'd0, bus.channel);
        end
      end
      ST_SETUP: begin
        if (phase_end) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          din_d   = cmd_bit(4'd0, ch_q);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_SHIFT: begin
        if (!phase_end) begin
          cnt_d = cnt_q + 8'd1;
        end else if (!sck_q) begin
          cnt_d = '0;
          sck_d = 1'b1;
        end else begin
          cnt_d = '0;
          sck_d = 1'b0;
          if ((bit_q >= 4'd5) && (bit_q <= 4'd14))
            shreg_d = {shreg_q[8:0], sync2_q};
          if (bit_q == 4'd15) begin
            state_d = ST_DONE;
          end else begin
            bit_d = bit_q + 4'd1;
            din_d = cmd_bit(bit_q + 4'd1, ch_q);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        din_d   = 1'b0;
        vpend_d = 1'b1;
`ifdef ADC_AVG2_EN
        data_out_d = avg_sum[10:1];
        prev_d     = shreg_q;
`else
        data_out_d = shreg_q;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (tick)
      pending_d = 1'b1;

    cs_hi_d = !cs_n_d ? '0 : ((cs_hi_q == '1) ? cs_hi_q : cs_hi_q + 8'd1);
  end

  assign bus.adc_cs_n   = cs_n_q;
  assign bus.adc_sck    = sck_q;
  assign bus.adc_din    = din_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = valid_q;
  assign bus.overrun    = overrun_q;
endmodule
